// File: rtl/harq_send_ctrl.sv
// HARQ send controller: reads a combine buffer (ping or pong), saturates the
// 10-bit LLRs to 8 bits and streams them out as 16-lane words with first/last markers.
module harq_send_ctrl (
  input  logic         i_core_clk,
  input  logic         i_rx_rstn,
  input  logic         i_ping_request,
  input  logic         i_pong_request,
  input  logic [15:0]  i_ping_add_amount,
  input  logic [15:0]  i_pong_add_amount,
  input  logic [3:0]   i_ping_user_index,
  input  logic [3:0]   i_pong_user_index,
  input  logic [159:0] i_ping_read_data,
  input  logic [159:0] i_pong_read_data,
  output logic         o_ping_busy,
  output logic         o_pong_busy,
  output logic         o_ping_comp,
  output logic         o_pong_comp,
  output logic [10:0]  o_rd_address,
  output logic         o_harq_valid,
  output logic [127:0] o_harq_data,
  output logic [3:0]   o_harq_user_index,
  output logic         o_harq_first,
  output logic         o_harq_last,
  output logic [1:0]   dbg_state
);

  // Handshake: a request is a level held by the combine stage until its comp
  // pulse; after that pulse the side is disarmed until its request is seen low.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state;
  logic        side_q;
  logic        last_pong;
  logic        ping_armed;
  logic        pong_armed;
  logic [3:0]  user_q;
  logic [3:0]  rem_q;
  logic [12:0] n_q;
  logic [12:0] cnt_q;
  logic        drain_q;
  logic        p1_valid;
  logic        p1_first;
  logic        p1_last;

  logic        ping_ok;
  logic        pong_ok;
  logic        grant;
  logic        pick_pong;
  logic [15:0] sel_amount;
  logic [3:0]  sel_user;
  logic [12:0] n_words;

  assign dbg_state = state;

  always_comb begin
    ping_ok    = i_ping_request & ping_armed;
    pong_ok    = i_pong_request & pong_armed;
    grant      = ping_ok | pong_ok;
    pick_pong  = pong_ok & (~ping_ok | ~last_pong);
    sel_amount = pick_pong ? i_pong_add_amount : i_ping_add_amount;
    sel_user   = pick_pong ? i_pong_user_index : i_ping_user_index;
    // Ceiling division by 16 without a carry-out term.
    n_words    = {1'b0, sel_amount[15:4]} + {12'd0, |sel_amount[3:0]};
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state        <= IDLE;
      side_q       <= 1'b0;
      last_pong    <= 1'b1;
      ping_armed   <= 1'b1;
      pong_armed   <= 1'b1;
      user_q       <= '0;
      rem_q        <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      o_rd_address <= '0;
      o_ping_busy  <= 1'b0;
      o_pong_busy  <= 1'b0;
      o_ping_comp  <= 1'b0;
      o_pong_comp  <= 1'b0;
      p1_valid     <= 1'b0;
      p1_first     <= 1'b0;
      p1_last      <= 1'b0;
    end else begin
      p1_valid    <= 1'b0;
      p1_first    <= 1'b0;
      p1_last     <= 1'b0;
      o_ping_comp <= 1'b0;
      o_pong_comp <= 1'b0;
      if (!i_ping_request) ping_armed <= 1'b1;
      if (!i_pong_request) pong_armed <= 1'b1;
      case (state)
        IDLE: begin
          if (grant) begin
            side_q       <= pick_pong;
            last_pong    <= pick_pong;
            user_q       <= sel_user;
            rem_q        <= sel_amount[3:0];
            n_q          <= n_words;
            cnt_q        <= '0;
            o_rd_address <= '0;
            o_ping_busy  <= ~pick_pong;
            o_pong_busy  <= pick_pong;
            if (n_words == 13'd0) begin
              state       <= DONE;
              o_ping_comp <= ~pick_pong;
              o_pong_comp <= pick_pong;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          p1_valid <= 1'b1;
          p1_first <= (cnt_q == 13'd0);
          p1_last  <= (cnt_q == n_q - 13'd1);
          if (cnt_q == n_q - 13'd1) begin
            state        <= DRAIN;
            drain_q      <= 1'b0;
            o_rd_address <= '0;
          end else begin
            cnt_q        <= cnt_q + 13'd1;
            o_rd_address <= cnt_q[10:0] + 11'd1;
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state       <= DONE;
            o_ping_comp <= ~side_q;
            o_pong_comp <= side_q;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          o_ping_busy <= 1'b0;
          o_pong_busy <= 1'b0;
          // Overrides the re-arm above: the served request is still high here.
          if (side_q) pong_armed <= 1'b0;
          else        ping_armed <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [159:0] src;
  logic [9:0]   lane;
  logic [7:0]   sat;
  logic [127:0] word_d;

  always_comb begin
    src    = side_q ? i_pong_read_data : i_ping_read_data;
    lane   = '0;
    sat    = '0;
    word_d = '0;
    for (int k = 0; k < 16; k++) begin
      lane = src[k*10 +: 10];
      if (lane[9:7] == 3'b000 || lane[9:7] == 3'b111) sat = lane[7:0];
      else if (lane[9])                               sat = 8'h80;
      else                                            sat = 8'h7f;
      // Lanes past the amount in a partial final word carry no LLR.
      if (p1_last && rem_q != 4'd0 && 5'(k) >= {1'b0, rem_q}) sat = 8'h00;
      word_d[k*8 +: 8] = sat;
    end
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      o_harq_valid      <= 1'b0;
      o_harq_data       <= '0;
      o_harq_user_index <= '0;
      o_harq_first      <= 1'b0;
      o_harq_last       <= 1'b0;
    end else begin
      o_harq_valid      <= p1_valid;
      o_harq_first      <= p1_first;
      o_harq_last       <= p1_last;
      o_harq_data       <= p1_valid ? word_d : '0;
      o_harq_user_index <= p1_valid ? user_q : '0;
    end
  end

endmodule
